// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe controller: cell/winner codes, FSM states
// and the row/column to flattened-cell index helper.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned GRID_W    = 2 * NUM_CELLS;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Cell (r,c) lives at grid bits [cell_index*2 +: 2]; out-of-range rows/cols
    // produce indices the caller must reject separately.
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/ttt_line_judge.sv
// Combinational board judge: does the given player own any of the 8 lines,
// and is every cell occupied.
module ttt_line_judge
    import ttt_pkg::*;
(
    input  logic [GRID_W-1:0] grid_i,
    input  logic [1:0]        player_i,
    output logic              win_o,
    output logic              full_o
);

    logic [NUM_CELLS-1:0] own;
    logic [NUM_CELLS-1:0] used;

    always_comb begin
        own  = '0;
        used = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            own[i]  = (grid_i[2*i +: 2] == player_i);
            used[i] = (grid_i[2*i +: 2] != CELL_EMPTY);
        end
    end

    assign win_o = (&own[2:0]) | (&own[5:3]) | (&own[8:6])
                 | (own[0] & own[3] & own[6])
                 | (own[1] & own[4] & own[7])
                 | (own[2] & own[5] & own[8])
                 | (own[0] & own[4] & own[8])
                 | (own[2] & own[4] & own[6]);

    assign full_o = &used;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer and board owner. Optional per-turn forfeit timer
// is compiled in with TTT_TURN_TIMER_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, no game; moves rejected until new_game
// ST_PLAY  | waiting for the active player's move
// ST_CHECK | one cycle judging the board after an accepted move
// ST_DONE  | game decided; grid and winner held until new_game
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT = 500_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              new_game,
    input  logic              move_valid,
    input  logic [1:0]        move_row,
    input  logic [1:0]        move_col,
    output logic [GRID_W-1:0] grid,
    output logic [1:0]        turn,
    output logic              move_ack,
    output logic              move_err,
    output logic [1:0]        winner,
    output logic              game_over,
    output logic              timeout
);

    state_t             state_q;
    logic [1:0]         active_q;
    logic [GRID_W-1:0]  grid_q;
    logic [1:0]         turn_q;
    logic               ack_q;
    logic               err_q;
    logic [1:0]         winner_q;
    logic               over_q;
    logic               timeout_q;

    logic [3:0]         idx;
    logic [1:0]         cell_val;
    logic [GRID_W-1:0]  grid_wr;
    logic               legal;
    logic [1:0]         other;
    logic               line_win;
    logic               board_full;
    logic               expire;

    // Row/col range is checked explicitly: e.g. (0,3) aliases onto cell (1,0).
    always_comb begin
        idx      = cell_index(move_row, move_col);
        cell_val = CELL_EMPTY;
        grid_wr  = grid_q;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i)) begin
                cell_val          = grid_q[2*i +: 2];
                grid_wr[2*i +: 2] = active_q;
            end
        end
        legal = move_valid && (move_row < 2'd3) && (move_col < 2'd3) && (cell_val == CELL_EMPTY);
    end

    assign other = (active_q == CELL_P1) ? CELL_P2 : CELL_P1;

    ttt_line_judge u_judge (
        .grid_i   (grid_q),
        .player_i (active_q),
        .win_o    (line_win),
        .full_o   (board_full)
    );

`ifdef TTT_TURN_TIMER_EN
    localparam int unsigned TMR_W = $clog2(TURN_TIMEOUT);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    assign expire = (state_q == ST_PLAY) && (tmr_q == TMR_W'(TURN_TIMEOUT - 1));

    always_comb begin
        tmr_d = tmr_q;
        if (new_game || state_q == ST_CHECK || (state_q == ST_PLAY && (legal || expire))) begin
            tmr_d = '0;
        end else if (state_q == ST_PLAY) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TURN_TIMEOUT;
    assign expire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            active_q  <= CELL_P1;
            grid_q    <= '0;
            turn_q    <= 2'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            winner_q  <= WIN_NONE;
            over_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (new_game) begin
                state_q  <= ST_PLAY;
                active_q <= CELL_P1;
                grid_q   <= '0;
                turn_q   <= CELL_P1;
                winner_q <= WIN_NONE;
                over_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        if (legal) begin
                            grid_q  <= grid_wr;
                            ack_q   <= 1'b1;
                            turn_q  <= 2'd0;
                            state_q <= ST_CHECK;
                        end else begin
                            err_q <= move_valid;
                            if (expire) begin
                                timeout_q <= 1'b1;
                                active_q  <= other;
                                turn_q    <= other;
                            end
                        end
                    end
                    ST_CHECK: begin
                        err_q <= move_valid;
                        if (line_win) begin
                            winner_q <= active_q;
                            over_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else if (board_full) begin
                            winner_q <= WIN_DRAW;
                            over_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            active_q <= other;
                            turn_q   <= other;
                            state_q  <= ST_PLAY;
                        end
                    end
                    default: begin
                        err_q <= move_valid;
                    end
                endcase
            end
        end
    end

    assign grid      = grid_q;
    assign turn      = turn_q;
    assign move_ack  = ack_q;
    assign move_err  = err_q;
    assign winner    = winner_q;
    assign game_over = over_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: vector table for the main game flow plus
// hand-written draw/diagonal, reset-in-CHECK and turn-timer sequences.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_row = 2'd0;
    logic [1:0]  move_col = 2'd0;
    logic [17:0] grid;
    logic [1:0]  turn;
    logic        move_ack;
    logic        move_err;
    logic [1:0]  winner;
    logic        game_over;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.TURN_TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_row   (move_row),
        .move_col   (move_col),
        .grid       (grid),
        .turn       (turn),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .winner     (winner),
        .game_over  (game_over),
        .timeout    (timeout)
    );

    typedef struct {
        logic        ng;
        logic        mv;
        logic [1:0]  r;
        logic [1:0]  c;
        logic [17:0] grid;
        logic [1:0]  turn;
        logic        ack;
        logic        err;
        logic [1:0]  win;
        logic        over;
    } vec_t;

    vec_t vt[$];

    function automatic logic [17:0] cl(input int r, input int c, input logic [1:0] p);
        logic [17:0] v;
        v = 18'(p);
        return v << ((r * 3 + c) * 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [17:0] g, input logic [1:0] t,
                        input logic a, input logic e, input logic [1:0] w,
                        input logic o, input logic to);
        chk($sformatf("%s.grid", tag), 32'(grid), 32'(g));
        chk($sformatf("%s.turn", tag), 32'(turn), 32'(t));
        chk($sformatf("%s.ack", tag), 32'(move_ack), 32'(a));
        chk($sformatf("%s.err", tag), 32'(move_err), 32'(e));
        chk($sformatf("%s.winner", tag), 32'(winner), 32'(w));
        chk($sformatf("%s.over", tag), 32'(game_over), 32'(o));
        chk($sformatf("%s.timeout", tag), 32'(timeout), 32'(to));
    endtask

    task automatic cycle(input logic ng, input logic mv, input logic [1:0] r, input logic [1:0] c);
        new_game   = ng;
        move_valid = mv;
        move_row   = r;
        move_col   = c;
        @(posedge clk);
        #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
    endtask

    task automatic add(input logic ng, input logic mv, input logic [1:0] r, input logic [1:0] c,
                       input logic [17:0] g, input logic [1:0] t, input logic a,
                       input logic e, input logic [1:0] w, input logic o);
        vec_t v;
        v = '{ng, mv, r, c, g, t, a, e, w, o};
        vt.push_back(v);
    endtask

    task automatic play_game(input string tag, input int rs[9], input int cs[9],
                             input logic [1:0] exp_win);
        logic [17:0] g;
        g = '0;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 9; i++) begin
            g = g | cl(rs[i], cs[i], (i % 2 == 0) ? 2'd1 : 2'd2);
            cycle(1'b0, 1'b1, 2'(rs[i]), 2'(cs[i]));
            chk($sformatf("%s.ack%0d", tag, i), 32'(move_ack), 32'd1);
            chk($sformatf("%s.grid%0d", tag, i), 32'(grid), 32'(g));
            cycle(1'b0, 1'b0, 2'd0, 2'd0);
            if (i < 8) chk($sformatf("%s.turn%0d", tag, i), 32'(turn), (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        outs({tag, ".end"}, g, 2'd0, 1'b0, 1'b0, exp_win, 1'b1, 1'b0);
    endtask

    initial begin : main
        logic [17:0] g_a, g_b, g_c, g_d, g_e;
        int dr_r[9] = '{0, 0, 0, 1, 1, 2, 2, 1, 2};
        int dr_c[9] = '{0, 1, 2, 1, 0, 0, 1, 2, 2};
        int dg_r[9] = '{0, 0, 0, 1, 1, 2, 2, 1, 2};
        int dg_c[9] = '{0, 1, 2, 0, 1, 0, 1, 2, 2};

        g_a = cl(0, 0, 2'd1);
        g_b = g_a | cl(1, 0, 2'd2);
        g_c = g_b | cl(0, 1, 2'd1);
        g_d = g_c | cl(1, 1, 2'd2);
        g_e = g_d | cl(0, 2, 2'd1);

        //   ng    mv    r     c     grid             turn  ack   err   win   over
        add(1'b0, 1'b1, 2'd0, 2'd0, 18'd0,           2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b0, 2'd0, 2'd0, 18'd0,           2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 2'd1, 2'd1, 18'd0,           2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'd0, g_a,             2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd2, 2'd2, g_a,             2'd2, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, g_a,             2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'd0, g_a,             2'd2, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd3, 2'd0, g_a,             2'd2, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'd3, g_a,             2'd2, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'd0, g_b,             2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, g_b,             2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'd1, g_c,             2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, g_c,             2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'd1, g_d,             2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, g_d,             2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'd2, g_e,             2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, g_e,             2'd0, 1'b0, 1'b0, 2'd1, 1'b1);
        add(1'b0, 1'b1, 2'd2, 2'd2, g_e,             2'd0, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 2'd0, 18'd0,           2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 2'd2, 2'd2, cl(2, 2, 2'd1),  2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 2'd0, 18'd0,           2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'd0, 18'd0,           2'd1, 1'b0, 1'b0, 2'd0, 1'b0);

        #1 resetn = 1'b0;
        #10;
        outs("reset", 18'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            cycle(vt[i].ng, vt[i].mv, vt[i].r, vt[i].c);
            outs($sformatf("vec%0d", i), vt[i].grid, vt[i].turn, vt[i].ack,
                 vt[i].err, vt[i].win, vt[i].over, 1'b0);
        end

        play_game("draw", dr_r, dr_c, 2'd3);
        play_game("diag9", dg_r, dg_c, 2'd1);

        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 2'd1, 2'd1);
        chk("rst_chk.ack", 32'(move_ack), 32'd1);
        #2 resetn = 1'b0;
        #1;
        outs("rst_chk", 18'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        resetn = 1'b1;
        cycle(1'b0, 1'b1, 2'd0, 2'd0);
        outs("post_rst", 18'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        outs("post_rst_ng", 18'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

`ifdef TTT_TURN_TIMER_EN
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        outs("tmr_pre", 18'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, 2'd0);
        outs("tmr_exp", 18'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 2'd0);
        chk("tmr_pulse_end", 32'(timeout), 32'd0);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 2'd1, 2'd1);
        outs("tmr_move_wins", cl(1, 1, 2'd2), 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
`else
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        outs("no_tmr", 18'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
